// File: rtl/loop_issuer.sv
// loop_issuer: producer side of the superscalar instruction queue.
// Accepts one decoded, loop-annotated instruction at a time and unrolls it into
// queue pushes of up to SUPERSCALAR_WIDTH copies each. Cache and main-memory
// addresses advance by their stride times the copies in each push. When the queue
// reports that its virtual-array position is exhausted, pushing stops, the queue is
// drained, a one-cycle queue reset is pulsed, and the interrupted loop resumes.
//
// Ports:
//   clk_i, reset_i            clock, asynchronous active-high reset
//   in_valid_i / in_ready_o   decoder handshake; transfer on both high at a rising edge
//   in_*_i                    instruction type, iteration count, base addresses,
//                             per-copy strides and opcode payloads
//   q_we_o                    push strobe; q_copy_count_o = copies in this push - 1
//   q_*_o                     push data, taken straight from the working registers
//   q_needs_reset_i, q_empty_i queue status
//   q_reset_o                 one-cycle queue position reset
//   busy_o                    a loop is in flight
module loop_issuer #(
  parameter int unsigned SUPERSCALAR_WIDTH     = 16,
  parameter int unsigned LOG_SUPERSCALAR_WIDTH = 4,
  parameter int unsigned ADDR_WIDTH            = 18,
  parameter int unsigned ITER_WIDTH            = 16
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic                             in_valid_i,
  output logic                             in_ready_o,
  input  logic [1:0]                       in_instr_type_i,
  input  logic [ITER_WIDTH-1:0]            in_iterations_i,
  input  logic [ADDR_WIDTH-1:0]            in_cache_addr_i,
  input  logic [ADDR_WIDTH-1:0]            in_main_mem_addr_i,
  input  logic [ADDR_WIDTH-1:0]            in_d_cache_addr_i,
  input  logic [ADDR_WIDTH-1:0]            in_d_main_mem_addr_i,
  input  logic [9:0]                       in_arith_instr_i,
  input  logic [8:0]                       in_ram_instr_i,
  input  logic [9:0]                       in_ld_st_instr_i,
  output logic                             q_we_o,
  output logic [1:0]                       q_instr_type_o,
  output logic [LOG_SUPERSCALAR_WIDTH-1:0] q_copy_count_o,
  output logic [ADDR_WIDTH-1:0]            q_cache_addr_o,
  output logic [ADDR_WIDTH-1:0]            q_main_mem_addr_o,
  output logic [ADDR_WIDTH-1:0]            q_d_cache_addr_o,
  output logic [ADDR_WIDTH-1:0]            q_d_main_mem_addr_o,
  output logic [9:0]                       q_arith_instr_o,
  output logic [8:0]                       q_ram_instr_o,
  output logic [9:0]                       q_ld_st_instr_o,
  input  logic                             q_needs_reset_i,
  input  logic                             q_empty_i,
  output logic                             q_reset_o,
  output logic                             busy_o
);

  localparam int unsigned ChunkW = LOG_SUPERSCALAR_WIDTH + 1;

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StQreset} state_e;

  state_e                  state_q, state_d;
  logic [1:0]              type_q, type_d;
  logic [ITER_WIDTH-1:0]   remaining_q, remaining_d;
  logic [ADDR_WIDTH-1:0]   cache_addr_q, cache_addr_d;
  logic [ADDR_WIDTH-1:0]   main_addr_q, main_addr_d;
  logic [ADDR_WIDTH-1:0]   d_cache_q, d_cache_d;
  logic [ADDR_WIDTH-1:0]   d_main_q, d_main_d;
  logic [9:0]              arith_q, arith_d;
  logic [8:0]              ram_q, ram_d;
  logic [9:0]              ld_st_q, ld_st_d;

  logic [ChunkW-1:0]       chunk, chunk_m1;
  logic [ADDR_WIDTH-1:0]   cache_step, main_step;

  // Copies in the current push: min(remaining, SUPERSCALAR_WIDTH).
  always_comb begin
    if (remaining_q > ITER_WIDTH'(SUPERSCALAR_WIDTH)) begin
      chunk = ChunkW'(SUPERSCALAR_WIDTH);
    end else begin
      chunk = remaining_q[ChunkW-1:0];
    end
    chunk_m1 = chunk - ChunkW'(1);
  end

  // stride * chunk as shift-add; chunk is small so this stays a short adder chain.
  always_comb begin
    cache_step = '0;
    main_step  = '0;
    for (int i = 0; i < int'(ChunkW); i++) begin
      if (chunk[i]) begin
        cache_step = cache_step + (d_cache_q << i);
        main_step  = main_step + (d_main_q << i);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    type_d       = type_q;
    remaining_d  = remaining_q;
    cache_addr_d = cache_addr_q;
    main_addr_d  = main_addr_q;
    d_cache_d    = d_cache_q;
    d_main_d     = d_main_q;
    arith_d      = arith_q;
    ram_d        = ram_q;
    ld_st_d      = ld_st_q;
    in_ready_o   = 1'b0;
    q_we_o       = 1'b0;
    q_reset_o    = 1'b0;

    unique case (state_q)
      StIdle: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          type_d       = in_instr_type_i;
          remaining_d  = in_iterations_i;
          cache_addr_d = in_cache_addr_i;
          main_addr_d  = in_main_mem_addr_i;
          d_cache_d    = in_d_cache_addr_i;
          d_main_d     = in_d_main_mem_addr_i;
          arith_d      = in_arith_instr_i;
          ram_d        = in_ram_instr_i;
          ld_st_d      = in_ld_st_instr_i;
          // A zero-iteration loop is consumed without any push.
          if (in_iterations_i != '0) begin
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        if (q_needs_reset_i) begin
          // Stall wins over everything, including the final chunk.
          state_d = StDrain;
        end else begin
          q_we_o       = 1'b1;
          cache_addr_d = cache_addr_q + cache_step;
          main_addr_d  = main_addr_q + main_step;
          remaining_d  = remaining_q - ITER_WIDTH'(chunk);
          if (remaining_q == ITER_WIDTH'(chunk)) begin
            state_d = StIdle;
          end
        end
      end
      StDrain: begin
        if (q_empty_i) begin
          state_d = StQreset;
        end
      end
      StQreset: begin
        q_reset_o = 1'b1;
        state_d   = StIssue;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= StIdle;
      type_q       <= '0;
      remaining_q  <= '0;
      cache_addr_q <= '0;
      main_addr_q  <= '0;
      d_cache_q    <= '0;
      d_main_q     <= '0;
      arith_q      <= '0;
      ram_q        <= '0;
      ld_st_q      <= '0;
    end else begin
      state_q      <= state_d;
      type_q       <= type_d;
      remaining_q  <= remaining_d;
      cache_addr_q <= cache_addr_d;
      main_addr_q  <= main_addr_d;
      d_cache_q    <= d_cache_d;
      d_main_q     <= d_main_d;
      arith_q      <= arith_d;
      ram_q        <= ram_d;
      ld_st_q      <= ld_st_d;
    end
  end

  // Copy count is only meaningful while issuing; hold it at zero otherwise.
  assign q_copy_count_o      = (state_q == StIssue) ? chunk_m1[LOG_SUPERSCALAR_WIDTH-1:0] : '0;
  assign q_instr_type_o      = type_q;
  assign q_cache_addr_o      = cache_addr_q;
  assign q_main_mem_addr_o   = main_addr_q;
  assign q_d_cache_addr_o    = d_cache_q;
  assign q_d_main_mem_addr_o = d_main_q;
  assign q_arith_instr_o     = arith_q;
  assign q_ram_instr_o       = ram_q;
  assign q_ld_st_instr_o     = ld_st_q;
  assign busy_o              = (state_q != StIdle);

endmodule

// File: tb/tb_loop_issuer.sv
module tb_loop_issuer;

  localparam logic [1:0] TypeRam   = 2'd0;
  localparam logic [1:0] TypeLdSt  = 2'd1;
  localparam logic [1:0] TypeArith = 2'd2;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_instr_type;
  logic [15:0] in_iterations;
  logic [17:0] in_cache_addr, in_main_mem_addr, in_d_cache_addr, in_d_main_mem_addr;
  logic [9:0]  in_arith_instr;
  logic [8:0]  in_ram_instr;
  logic [9:0]  in_ld_st_instr;
  logic        q_we;
  logic [1:0]  q_instr_type;
  logic [3:0]  q_copy_count;
  logic [17:0] q_cache_addr, q_main_mem_addr, q_d_cache_addr, q_d_main_mem_addr;
  logic [9:0]  q_arith_instr;
  logic [8:0]  q_ram_instr;
  logic [9:0]  q_ld_st_instr;
  logic        q_needs_reset, q_empty, q_reset, busy;

  always #5 clk = ~clk;

  loop_issuer dut (
    .clk_i               (clk),
    .reset_i             (reset),
    .in_valid_i          (in_valid),
    .in_ready_o          (in_ready),
    .in_instr_type_i     (in_instr_type),
    .in_iterations_i     (in_iterations),
    .in_cache_addr_i     (in_cache_addr),
    .in_main_mem_addr_i  (in_main_mem_addr),
    .in_d_cache_addr_i   (in_d_cache_addr),
    .in_d_main_mem_addr_i(in_d_main_mem_addr),
    .in_arith_instr_i    (in_arith_instr),
    .in_ram_instr_i      (in_ram_instr),
    .in_ld_st_instr_i    (in_ld_st_instr),
    .q_we_o              (q_we),
    .q_instr_type_o      (q_instr_type),
    .q_copy_count_o      (q_copy_count),
    .q_cache_addr_o      (q_cache_addr),
    .q_main_mem_addr_o   (q_main_mem_addr),
    .q_d_cache_addr_o    (q_d_cache_addr),
    .q_d_main_mem_addr_o (q_d_main_mem_addr),
    .q_arith_instr_o     (q_arith_instr),
    .q_ram_instr_o       (q_ram_instr),
    .q_ld_st_instr_o     (q_ld_st_instr),
    .q_needs_reset_i     (q_needs_reset),
    .q_empty_i           (q_empty),
    .q_reset_o           (q_reset),
    .busy_o              (busy)
  );

  typedef struct {
    logic [3:0]  cc;
    logic [1:0]  t;
    logic [17:0] ca, ma, dca, dma;
    logic [9:0]  ar;
    logic [8:0]  rm;
    logic [9:0]  ls;
  } push_t;

  push_t sb[$];
  int checks = 0;
  int failures = 0;
  int push_cnt = 0;
  int qreset_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard: every push is compared against the oldest expected push.
  always @(negedge clk) begin
    if (!reset && q_we) begin
      push_cnt++;
      if (sb.size() == 0) begin
        check("unexpected_push", 32'd1, 32'd0);
      end else begin
        push_t e;
        e = sb.pop_front();
        check("sb_copy_count", 32'(q_copy_count), 32'(e.cc));
        check("sb_cache_addr", 32'(q_cache_addr), 32'(e.ca));
        check("sb_main_addr", 32'(q_main_mem_addr), 32'(e.ma));
        check("sb_type", 32'(q_instr_type), 32'(e.t));
        check("sb_d_cache", 32'(q_d_cache_addr), 32'(e.dca));
        check("sb_d_main", 32'(q_d_main_mem_addr), 32'(e.dma));
        check("sb_arith", 32'(q_arith_instr), 32'(e.ar));
        check("sb_ram", 32'(q_ram_instr), 32'(e.rm));
        check("sb_ld_st", 32'(q_ld_st_instr), 32'(e.ls));
      end
    end
    if (!reset && q_reset) qreset_cnt++;
  end

  task automatic drive(input logic [1:0] t, input int iter, input logic [17:0] ca,
                       input logic [17:0] dca, input logic [17:0] ma, input logic [17:0] dma);
    in_instr_type      = t;
    in_iterations      = 16'(iter);
    in_cache_addr      = ca;
    in_d_cache_addr    = dca;
    in_main_mem_addr   = ma;
    in_d_main_mem_addr = dma;
    in_arith_instr     = 10'($urandom);
    in_ram_instr       = 9'($urandom);
    in_ld_st_instr     = 10'($urandom);
  endtask

  // Expected pushes for the instruction currently on the input bus.
  task automatic model_push();
    int rem;
    int ch;
    push_t e;
    rem  = int'(in_iterations);
    e.t  = in_instr_type;
    e.ca = in_cache_addr;
    e.ma = in_main_mem_addr;
    e.dca = in_d_cache_addr;
    e.dma = in_d_main_mem_addr;
    e.ar = in_arith_instr;
    e.rm = in_ram_instr;
    e.ls = in_ld_st_instr;
    while (rem > 0) begin
      ch   = (rem > 16) ? 16 : rem;
      e.cc = 4'(ch - 1);
      sb.push_back(e);
      e.ca = 18'(int'(e.ca) + int'(e.dca) * ch);
      e.ma = 18'(int'(e.ma) + int'(e.dma) * ch);
      rem  = rem - ch;
    end
  endtask

  // Offer one instruction while idle; returns 1ns after the accepting edge.
  task automatic send(input logic [1:0] t, input int iter, input logic [17:0] ca,
                      input logic [17:0] dca, input logic [17:0] ma, input logic [17:0] dma);
    drive(t, iter, ca, dca, ma, dma);
    model_push();
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (!in_ready && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("idle_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int p0;
    reset = 1'b1;
    in_valid = 1'b0;
    q_needs_reset = 1'b0;
    q_empty = 1'b0;
    drive(TypeRam, 0, '0, '0, '0, '0);
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_q_we", 32'(q_we), 32'd0);
    check("rst_q_reset", 32'(q_reset), 32'd0);
    check("rst_cache", 32'(q_cache_addr), 32'd0);
    check("rst_copy_count", 32'(q_copy_count), 32'd0);
    check("rst_arith", 32'(q_arith_instr), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Multi-chunk loop: 40 iterations in three back-to-back pushes.
    send(TypeArith, 40, 18'h00100, 18'd2, 18'h01000, 18'd4);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mc_we", 32'(q_we), 32'd1);
      check("mc_cc", 32'(q_copy_count), (i == 2) ? 32'd7 : 32'd15);
      check("mc_cache", 32'(q_cache_addr), 32'h100 + 32'(i) * 32'h20);
      check("mc_main", 32'(q_main_mem_addr), 32'h1000 + 32'(i) * 32'h40);
    end
    @(negedge clk);
    check("mc_ready_after", 32'(in_ready), 32'd1);
    check("mc_we_after", 32'(q_we), 32'd0);

    // Edge counts: 1 and 16 iterations give a single push each.
    send(TypeLdSt, 1, 18'h00AAA, 18'd7, 18'h00555, 18'd9);
    @(negedge clk);
    check("one_we", 32'(q_we), 32'd1);
    check("one_cc", 32'(q_copy_count), 32'd0);
    @(negedge clk);
    check("one_done", 32'(in_ready), 32'd1);
    send(TypeRam, 16, 18'h01234, 18'd3, 18'h04321, 18'd5);
    @(negedge clk);
    check("sixteen_cc", 32'(q_copy_count), 32'd15);
    @(negedge clk);
    check("sixteen_done", 32'(q_we), 32'd0);

    // Zero iterations: accepted and dropped.
    p0 = push_cnt;
    send(TypeArith, 0, 18'h00777, 18'd1, 18'h00888, 18'd1);
    @(negedge clk);
    check("zero_busy", 32'(busy), 32'd0);
    check("zero_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    check("zero_pushes", 32'(push_cnt), 32'(p0));

    // Queue reset stall in the middle of a 48-iteration loop.
    send(TypeLdSt, 48, 18'h00200, 18'd3, 18'h04000, 18'd5);
    @(negedge clk);
    check("stall_first_we", 32'(q_we), 32'd1);
    @(posedge clk);
    #1;
    q_needs_reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_no_we", 32'(q_we), 32'd0);
      check("stall_no_qreset", 32'(q_reset), 32'd0);
      @(posedge clk);
      #1;
    end
    q_empty = 1'b1;
    q_needs_reset = 1'b0;
    @(negedge clk);
    check("stall_empty_cycle_we", 32'(q_we), 32'd0);
    check("stall_empty_cycle_qr", 32'(q_reset), 32'd0);
    @(negedge clk);
    check("stall_qreset", 32'(q_reset), 32'd1);
    check("stall_qreset_we", 32'(q_we), 32'd0);
    q_empty = 1'b0;
    @(negedge clk);
    check("stall_resume2_we", 32'(q_we), 32'd1);
    check("stall_resume2_addr", 32'(q_cache_addr), 32'h200 + 32'd48);
    check("stall_resume2_qr", 32'(q_reset), 32'd0);
    @(negedge clk);
    check("stall_resume3_addr", 32'(q_cache_addr), 32'h200 + 32'd96);
    check("stall_resume3_main", 32'(q_main_mem_addr), 32'h4000 + 32'd160);
    @(negedge clk);
    check("stall_done", 32'(in_ready), 32'd1);
    check("stall_qreset_count", 32'(qreset_cnt), 32'd1);

    // Cache address wraps modulo 2^18.
    send(TypeRam, 32, 18'h3FFF0, 18'd1, 18'h00010, 18'd2);
    @(negedge clk);
    @(negedge clk);
    check("wrap_cache", 32'(q_cache_addr), 32'd0);
    wait_idle(10);

    // Asynchronous reset during issue abandons the loop.
    send(TypeArith, 64, 18'h00300, 18'd1, 18'h00400, 18'd1);
    @(negedge clk);
    @(posedge clk);
    #2;
    reset = 1'b1;
    sb.delete();
    #1;
    check("arst_we", 32'(q_we), 32'd0);
    check("arst_ready", 32'(in_ready), 32'd1);
    check("arst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    p0 = push_cnt;
    repeat (5) @(negedge clk);
    check("arst_no_push", 32'(push_cnt), 32'(p0));
    check("arst_no_qreset", 32'(qreset_cnt), 32'd1);

    // Back-to-back: two 17-iteration instructions with in_valid held high.
    @(posedge clk);
    #1;
    drive(TypeLdSt, 17, 18'h00050, 18'd2, 18'h00060, 18'd3);
    model_push();
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    drive(TypeArith, 17, 18'h10000, 18'd6, 18'h20000, 18'd7);
    model_push();
    @(negedge clk);
    check("b2b_a1_we", 32'(q_we), 32'd1);
    check("b2b_a1_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("b2b_a2_we", 32'(q_we), 32'd1);
    check("b2b_a2_cc", 32'(q_copy_count), 32'd0);
    @(negedge clk);
    check("b2b_gap_we", 32'(q_we), 32'd0);
    check("b2b_gap_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("b2b_b1_we", 32'(q_we), 32'd1);
    @(negedge clk);
    check("b2b_b2_we", 32'(q_we), 32'd1);
    @(negedge clk);
    check("b2b_done", 32'(in_ready), 32'd1);

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
